// File: rtl/uart_baud_pkg.sv
// Shared definitions for the UART baud tick generator: rate select codes,
// preset divisor arithmetic and the oversample index width.
package uart_baud_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  function automatic int baud_rate(input logic [1:0] sel);
    case (sel)
      BAUD_2400:  return 2400;
      BAUD_4800:  return 4800;
      BAUD_9600:  return 9600;
      default:    return 19200;
    endcase
  endfunction

  // Integer clocks per oversample period, truncated.
  function automatic longint preset_int(input int clk_hz, input int oversample,
                                        input int baud);
    return longint'(clk_hz) / (longint'(oversample) * longint'(baud));
  endfunction

  // Fractional part in units of 1/2^frac_w, truncated.
  function automatic longint preset_frac(input int clk_hz, input int oversample,
                                         input int frac_w, input int baud);
    longint scaled;
    scaled = (longint'(clk_hz) << frac_w) / (longint'(oversample) * longint'(baud));
    return scaled % (longint'(1) << frac_w);
  endfunction

  function automatic int os_idx_width(input int oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen_frac_div.sv
// Fractional clock divider: cycle counter plus carry accumulator producing one
// registered tick per oversample period; holds the active divisor for the period.
module uart_frac_div #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              resync,
  input  logic [DIV_W-1:0]  ld_div_i,
  input  logic [FRAC_W-1:0] ld_div_f,
  output logic              tick,
  output logic              wrap
);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_i;
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W-1:0] div_f;
  logic [FRAC_W:0]   sum;
  logic [DIV_W:0]    term;
  logic              at_end;
  logic              idle;

  // The carry is derived from the accumulator held for the whole period, so
  // the period length is fixed from its first cycle.
  always_comb begin
    sum    = {1'b0, frac_acc} + {1'b0, div_f};
    term   = {1'b0, div_i} + {{DIV_W{1'b0}}, sum[FRAC_W]} - {{DIV_W{1'b0}}, 1'b1};
    at_end = ({1'b0, cnt} == term);
    // A zero divisor only exists straight after reset; treat it as idle so the
    // first active cycle already has a valid config.
    idle   = !enable || resync || (div_i == '0);
    wrap   = !idle && at_end;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      frac_acc <= '0;
      div_i    <= '0;
      div_f    <= '0;
      tick     <= 1'b0;
    end else if (idle) begin
      cnt      <= '0;
      frac_acc <= '0;
      div_i    <= ld_div_i;
      div_f    <= ld_div_f;
      tick     <= 1'b0;
    end else if (at_end) begin
      cnt      <= '0;
      frac_acc <= sum[FRAC_W-1:0];
      div_i    <= ld_div_i;
      div_f    <= ld_div_f;
      tick     <= 1'b1;
    end else begin
      cnt      <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      tick     <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// UART baud tick generator: oversample, mid-bit and end-of-bit enable pulses.
// Optional macro BAUD_CLK_OUT_EN adds a baud_clk square wave output.
module uart_baud_tick_gen
  import uart_baud_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [1:0]                            baud_sel,
  input  logic                                  cfg_custom,
  input  logic [DIV_W-1:0]                      cfg_div_int,
  input  logic [FRAC_W-1:0]                     cfg_div_frac,
  input  logic                                  resync,
  output logic                                  os_tick,
  output logic                                  mid_tick,
  output logic                                  bit_tick,
  output logic [os_idx_width(OVERSAMPLE)-1:0]   os_idx
`ifdef BAUD_CLK_OUT_EN
  , output logic                                baud_clk
`endif
);

  localparam int IDX_W = os_idx_width(OVERSAMPLE);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(OVERSAMPLE / 2);

  localparam logic [DIV_W-1:0] P_INT_2400  =
    DIV_W'(preset_int(CLK_HZ, OVERSAMPLE, baud_rate(BAUD_2400)));
  localparam logic [DIV_W-1:0] P_INT_4800  =
    DIV_W'(preset_int(CLK_HZ, OVERSAMPLE, baud_rate(BAUD_4800)));
  localparam logic [DIV_W-1:0] P_INT_9600  =
    DIV_W'(preset_int(CLK_HZ, OVERSAMPLE, baud_rate(BAUD_9600)));
  localparam logic [DIV_W-1:0] P_INT_19200 =
    DIV_W'(preset_int(CLK_HZ, OVERSAMPLE, baud_rate(BAUD_19200)));

  localparam logic [FRAC_W-1:0] P_FRAC_2400  =
    FRAC_W'(preset_frac(CLK_HZ, OVERSAMPLE, FRAC_W, baud_rate(BAUD_2400)));
  localparam logic [FRAC_W-1:0] P_FRAC_4800  =
    FRAC_W'(preset_frac(CLK_HZ, OVERSAMPLE, FRAC_W, baud_rate(BAUD_4800)));
  localparam logic [FRAC_W-1:0] P_FRAC_9600  =
    FRAC_W'(preset_frac(CLK_HZ, OVERSAMPLE, FRAC_W, baud_rate(BAUD_9600)));
  localparam logic [FRAC_W-1:0] P_FRAC_19200 =
    FRAC_W'(preset_frac(CLK_HZ, OVERSAMPLE, FRAC_W, baud_rate(BAUD_19200)));

  logic [DIV_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic [DIV_W-1:0]  ld_div_i;
  logic              wrap;
  logic [IDX_W-1:0]  idx_next;

  always_comb begin
    sel_int  = P_INT_2400;
    sel_frac = P_FRAC_2400;
    if (cfg_custom) begin
      sel_int  = cfg_div_int;
      sel_frac = cfg_div_frac;
    end else begin
      case (baud_sel)
        BAUD_2400:  begin sel_int = P_INT_2400;  sel_frac = P_FRAC_2400;  end
        BAUD_4800:  begin sel_int = P_INT_4800;  sel_frac = P_FRAC_4800;  end
        BAUD_9600:  begin sel_int = P_INT_9600;  sel_frac = P_FRAC_9600;  end
        default:    begin sel_int = P_INT_19200; sel_frac = P_FRAC_19200; end
      endcase
    end
    // Below two clocks the terminal compare could never be reached cleanly.
    ld_div_i = (sel_int < DIV_W'(2)) ? DIV_W'(2) : sel_int;
  end

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .resync   (resync),
    .ld_div_i (ld_div_i),
    .ld_div_f (sel_frac),
    .tick     (os_tick),
    .wrap     (wrap)
  );

  assign idx_next = os_idx + IDX_W'(1);

  // Index and bit-phase pulses update on the same edge that raises os_tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      os_idx   <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (!enable || resync) begin
      os_idx   <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (wrap) begin
      os_idx   <= idx_next;
      mid_tick <= (idx_next == HALF_IDX);
      bit_tick <= (idx_next == '0);
    end else begin
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

`ifdef BAUD_CLK_OUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_clk <= 1'b0;
    end else if (wrap) begin
      baud_clk <= !baud_clk;
    end
  end
`endif

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Directed self-checking bench for uart_baud_tick_gen at default parameters.
module tb_uart_baud_tick_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  baud_sel = 2'b00;
  logic        cfg_custom = 1'b0;
  logic [15:0] cfg_div_int = 16'd0;
  logic [3:0]  cfg_div_frac = 4'd0;
  logic        resync = 1'b0;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic [3:0]  os_idx;
`ifdef BAUD_CLK_OUT_EN
  logic        baud_clk;
`endif

  int vectors = 0;
  int miscompares = 0;

  uart_baud_tick_gen dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .baud_sel     (baud_sel),
    .cfg_custom   (cfg_custom),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .resync       (resync),
    .os_tick      (os_tick),
    .mid_tick     (mid_tick),
    .bit_tick     (bit_tick),
    .os_idx       (os_idx)
`ifdef BAUD_CLK_OUT_EN
    , .baud_clk   (baud_clk)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until os_tick is seen; n = cycles taken, -1 on timeout.
  task automatic wait_os(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (os_tick !== 1'b1 && n < limit);
    if (os_tick !== 1'b1) n = -1;
  endtask

  task automatic go_idle(input logic [1:0] sel);
    enable = 1'b0;
    resync = 1'b0;
    baud_sel = sel;
    step();
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    vectors++;
    if ({os_tick, mid_tick, bit_tick, os_idx} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0000000", {os_tick, mid_tick, bit_tick, os_idx});
    end
    reset_n = 1'b1;
    step();
    step();
    vectors++;
    if ({os_tick, mid_tick, bit_tick, os_idx} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b expected 0000000", {os_tick, mid_tick, bit_tick, os_idx});
    end
  endtask

  task automatic test_preset_19200();
    int pat [4] = '{162, 163, 163, 163};
    int last_os, last_bit, k, nbits, nmids;
`ifdef BAUD_CLK_OUT_EN
    logic bclk_prev;
    bclk_prev = baud_clk;
`endif
    cfg_custom = 1'b0;
    go_idle(2'b11);
    enable = 1'b1;
    last_os = 0; last_bit = 0; k = 0; nbits = 0; nmids = 0;
    for (int c = 1; c <= 3 * 2604 + 20; c++) begin
      step();
      if (os_tick === 1'b1) begin
        vectors++;
        if (c - last_os != pat[k % 4]) begin
          miscompares++;
          $display("FAIL p19200_period[%0d]: got %0d expected %0d", k, c - last_os, pat[k % 4]);
        end
        vectors++;
        if (int'(os_idx) != (k + 1) % 16) begin
          miscompares++;
          $display("FAIL p19200_os_idx[%0d]: got %0d expected %0d", k, os_idx, (k + 1) % 16);
        end
`ifdef BAUD_CLK_OUT_EN
        vectors++;
        if (baud_clk === bclk_prev) begin
          miscompares++;
          $display("FAIL p19200_baud_clk[%0d]: got %b expected %b", k, baud_clk, !bclk_prev);
        end
        bclk_prev = baud_clk;
`endif
        k++;
        last_os = c;
      end
      if (bit_tick === 1'b1) begin
        vectors++;
        if (c - last_bit != 2604) begin
          miscompares++;
          $display("FAIL p19200_bit_gap: got %0d expected 2604", c - last_bit);
        end
        last_bit = c;
        nbits++;
      end
      if (mid_tick === 1'b1) begin
        vectors++;
        if (c - last_bit < 1301 || c - last_bit > 1303) begin
          miscompares++;
          $display("FAIL p19200_mid_offset: got %0d expected 1302+-1", c - last_bit);
        end
        nmids++;
      end
    end
    vectors++;
    if (nbits != 3 || nmids != 3) begin
      miscompares++;
      $display("FAIL p19200_counts: got bits=%0d mids=%0d expected 3 and 3", nbits, nmids);
    end
  endtask

  task automatic test_preset_4800();
    int last_os, last_bit, k, nbits, nmids;
    cfg_custom = 1'b0;
    go_idle(2'b01);
    enable = 1'b1;
    last_os = 0; last_bit = 0; k = 0; nbits = 0; nmids = 0;
    for (int c = 1; c <= 2 * 10416 + 10; c++) begin
      step();
      if (os_tick === 1'b1) begin
        vectors++;
        if (c - last_os != 651 || int'(os_idx) != (k + 1) % 16) begin
          miscompares++;
          $display("FAIL p4800_tick[%0d]: got period %0d idx %0d expected 651 idx %0d",
                   k, c - last_os, os_idx, (k + 1) % 16);
        end
        k++;
        last_os = c;
      end
      if (bit_tick === 1'b1) begin
        vectors++;
        if (c - last_bit != 10416) begin
          miscompares++;
          $display("FAIL p4800_bit_gap: got %0d expected 10416", c - last_bit);
        end
        last_bit = c;
        nbits++;
      end
      if (mid_tick === 1'b1) begin
        vectors++;
        if (c - last_bit != 5208) begin
          miscompares++;
          $display("FAIL p4800_mid_offset: got %0d expected 5208", c - last_bit);
        end
        nmids++;
      end
    end
    vectors++;
    if (nbits != 2 || nmids != 2 || k != 32) begin
      miscompares++;
      $display("FAIL p4800_counts: got bits=%0d mids=%0d ticks=%0d expected 2 2 32", nbits, nmids, k);
    end
  endtask

  task automatic test_custom_clamp();
    int last_os, last_bit, nbits, bad;
    cfg_custom = 1'b1;
    cfg_div_int = 16'd1;
    cfg_div_frac = 4'd0;
    go_idle(2'b00);
    enable = 1'b1;
    last_os = 0; last_bit = 0; nbits = 0; bad = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (os_tick === 1'b1) begin
        if (c - last_os != 2) bad++;
        last_os = c;
      end
      if (bit_tick === 1'b1) begin
        vectors++;
        if (c - last_bit != 32) begin
          miscompares++;
          $display("FAIL clamp_bit_gap: got %0d expected 32", c - last_bit);
        end
        last_bit = c;
        nbits++;
      end
    end
    vectors++;
    if (bad != 0 || last_os != 70) begin
      miscompares++;
      $display("FAIL clamp_os_period: got %0d bad gaps, last tick %0d expected 0 and 70", bad, last_os);
    end
    vectors++;
    if (nbits != 2) begin
      miscompares++;
      $display("FAIL clamp_bit_count: got %0d expected 2", nbits);
    end
    cfg_custom = 1'b0;
  endtask

  task automatic test_sel_change();
    int n;
    cfg_custom = 1'b0;
    go_idle(2'b10);
    enable = 1'b1;
    wait_os(n, 2000);
    vectors++;
    if (n != 325) begin
      miscompares++;
      $display("FAIL selchg_first: got %0d expected 325", n);
    end
    for (int i = 0; i < 50; i++) step();
    baud_sel = 2'b00;
    wait_os(n, 2000);
    vectors++;
    if (n + 50 != 326) begin
      miscompares++;
      $display("FAIL selchg_running: got %0d expected 326", n + 50);
    end
    wait_os(n, 2000);
    vectors++;
    if (n != 1302) begin
      miscompares++;
      $display("FAIL selchg_new_rate: got %0d expected 1302", n);
    end
  endtask

  task automatic test_resync();
    int n, seen;
    cfg_custom = 1'b0;
    go_idle(2'b01);
    enable = 1'b1;
    wait_os(n, 2000);
    vectors++;
    if (n != 651) begin
      miscompares++;
      $display("FAIL resync_pre_period: got %0d expected 651", n);
    end
    for (int i = 0; i < 650; i++) step();
    vectors++;
    if (os_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL resync_pre_idx: got %0d expected 1", os_idx);
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    vectors++;
    if (os_tick !== 1'b0 || os_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL resync_suppress: got tick %b idx %0d expected 0 0", os_tick, os_idx);
    end
    wait_os(n, 2000);
    vectors++;
    if (n != 651 || os_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL resync_next: got %0d idx %0d expected 651 idx 1", n, os_idx);
    end
    resync = 1'b1;
    seen = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (os_tick !== 1'b0 || os_idx !== 4'd0) seen++;
    end
    resync = 1'b0;
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL resync_hold: got %0d active cycles expected 0", seen);
    end
    wait_os(n, 2000);
    vectors++;
    if (n != 651) begin
      miscompares++;
      $display("FAIL resync_hold_release: got %0d expected 651", n);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    cfg_custom = 1'b0;
    go_idle(2'b11);
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) step();
    vectors++;
    if (os_idx !== 4'd6) begin
      miscompares++;
      $display("FAIL endrop_mid_idx: got %0d expected 6", os_idx);
    end
    enable = 1'b0;
    step();
    vectors++;
    if ({os_tick, mid_tick, bit_tick, os_idx} !== 7'b0) begin
      miscompares++;
      $display("FAIL endrop_outputs: got %b expected 0000000", {os_tick, mid_tick, bit_tick, os_idx});
    end
    enable = 1'b1;
    wait_os(n, 2000);
    vectors++;
    if (n != 162 || os_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL endrop_restart: got %0d idx %0d expected 162 idx 1", n, os_idx);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cfg_custom = 1'b0;
    go_idle(2'b01);
    enable = 1'b1;
    wait_os(n, 2000);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({os_tick, mid_tick, bit_tick, os_idx} !== 7'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got %b expected 0000000", {os_tick, mid_tick, bit_tick, os_idx});
    end
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    enable = 1'b1;
    wait_os(n, 2000);
    vectors++;
    if (n != 651 || os_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL rstmid_restart: got %0d idx %0d expected 651 idx 1", n, os_idx);
    end
  endtask

  initial begin
    test_reset();
    test_preset_19200();
    test_preset_4800();
    test_custom_clamp();
    test_sel_change();
    test_resync();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
